// File: rtl/entity_stream_if.sv
// Byte-stream bus carrying entity descriptor packets into the loader.
//   data_in    : stream byte
//   data_valid : data_in is valid this cycle (one byte consumed per high cycle)
//   abort      : synchronous drop of any partial packet; wins over data_valid
// master drives the stream, slave (the loader) consumes it.
interface entity_stream_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       abort;

  modport master (
    output data_in,
    output data_valid,
    output abort
  );

  modport slave (
    input data_in,
    input data_valid,
    input abort
  );
endinterface

// File: rtl/entity_descriptor_loader.sv
// Entity descriptor loader: assembles three-byte descriptor packets from the
// byte stream into nine shadow entity slots and copies the whole shadow set to
// the active outputs on each rising edge of v_sync, so downstream never sees a
// half-updated scene.
//
// Packet: byte0 = {slot, id}, byte1 = {orient, 2'b00, ext}, byte2 = loc.
// Slot 4'hF in byte0 is a one-byte clear-all command. ext is kept only for
// slot 7 (array length).
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   stream          : entity_stream_if slave (data_in, data_valid, abort)
//   v_sync          : VGA vsync, same clock domain
//   entity_1..6     : active descriptors {id[3:0], orient[1:0], loc[7:0]}
//   entity_7_array  : active {id, orient, loc, length[3:0]}
//   entity_8_flip/9 : active descriptors
//   frame_commit    : one-cycle pulse after shadow is copied to active
//   pkt_err         : sticky bad-slot flag, cleared by clear-all
module entity_descriptor_loader #(
  parameter int unsigned NUM_SLOTS = 9,
  parameter logic [3:0]  UNUSED_ID = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  entity_stream_if.slave        stream,
  input  logic                  v_sync,
  output logic [13:0]           entity_1,
  output logic [13:0]           entity_2,
  output logic [13:0]           entity_3,
  output logic [13:0]           entity_4,
  output logic [13:0]           entity_5,
  output logic [13:0]           entity_6,
  output logic [17:0]           entity_7_array,
  output logic [13:0]           entity_8_flip,
  output logic [13:0]           entity_9_flip,
  output logic                  frame_commit,
  output logic                  pkt_err
);

  localparam logic [3:0]  CLEAR_SLOT = 4'hF;
  localparam logic [13:0] EMPTY_SLOT = {UNUSED_ID, 10'h000};

  typedef enum logic [1:0] {
    S_HDR,
    S_ATTR,
    S_LOC
  } state_t;

  state_t      state_q, state_d;

  logic [3:0]  slot_q;
  logic [3:0]  id_q;
  logic [1:0]  orient_q;
  logic [3:0]  ext_q;

  // Slot 7's length nibble is held beside its 14-bit descriptor so every slot
  // shares one uniform array.
  logic [13:0] shadow [NUM_SLOTS];
  logic [3:0]  shadow_len;
  logic [13:0] active [NUM_SLOTS];
  logic [3:0]  active_len;

  logic        v_sync_q;
  logic        take;
  logic        clear_all;
  logic        slot_ok;
  logic        commit;

  assign take      = stream.data_valid && !stream.abort;
  assign clear_all = take && (state_q == S_HDR) && (stream.data_in[7:4] == CLEAR_SLOT);
  assign slot_ok   = (slot_q >= 4'd1) && (slot_q <= 4'd9);
  assign commit    = v_sync && !v_sync_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stream.abort) begin
      state_d = S_HDR;
    end else if (stream.data_valid) begin
      case (state_q)
        S_HDR:   state_d = clear_all ? S_HDR : S_ATTR;
        S_ATTR:  state_d = S_LOC;
        S_LOC:   state_d = S_HDR;
        default: state_d = S_HDR;
      endcase
    end
  end

  // ------------------------------------------------- packet field latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      id_q     <= '0;
      orient_q <= '0;
      ext_q    <= '0;
    end else if (take) begin
      if (state_q == S_HDR && !clear_all) begin
        slot_q <= stream.data_in[7:4];
        id_q   <= stream.data_in[3:0];
      end
      if (state_q == S_ATTR) begin
        orient_q <= stream.data_in[7:6];
        ext_q    <= stream.data_in[3:0];
      end
    end
  end

  // --------------------------------------------------- shadow + error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) shadow[i] <= EMPTY_SLOT;
      shadow_len <= '0;
      pkt_err    <= 1'b0;
    end else if (clear_all) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) shadow[i] <= EMPTY_SLOT;
      shadow_len <= '0;
      pkt_err    <= 1'b0;
    end else if (take && state_q == S_LOC) begin
      if (slot_ok) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (slot_q == 4'(i + 1)) shadow[i] <= {id_q, orient_q, stream.data_in};
        end
        if (slot_q == 4'd7) shadow_len <= ext_q;
      end else begin
        pkt_err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- commit
  // Non-blocking copy means a shadow write on the commit edge lands only at
  // the following commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) active[i] <= EMPTY_SLOT;
      active_len   <= '0;
      v_sync_q     <= 1'b0;
      frame_commit <= 1'b0;
    end else begin
      v_sync_q     <= v_sync;
      frame_commit <= commit;
      if (commit) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) active[i] <= shadow[i];
        active_len <= shadow_len;
      end
    end
  end

  assign entity_1       = active[0];
  assign entity_2       = active[1];
  assign entity_3       = active[2];
  assign entity_4       = active[3];
  assign entity_5       = active[4];
  assign entity_6       = active[5];
  assign entity_7_array = {active[6], active_len};
  assign entity_8_flip  = active[7];
  assign entity_9_flip  = active[8];

endmodule

// File: tb/tb_entity_descriptor_loader.sv
// Self-checking bench for entity_descriptor_loader. A reference model of the
// shadow set is updated as packets are sent; each commit pushes a snapshot to
// a queue that is popped and compared when frame_commit is seen.
module tb_entity_descriptor_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic [13:0] e1, e2, e3, e4, e5, e6, e8, e9;
  logic [17:0] e7;
  logic        fc, err;

  entity_stream_if sif ();

  entity_descriptor_loader #(.NUM_SLOTS(9), .UNUSED_ID(4'hF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stream         (sif),
    .v_sync         (v_sync),
    .entity_1       (e1),
    .entity_2       (e2),
    .entity_3       (e3),
    .entity_4       (e4),
    .entity_5       (e5),
    .entity_6       (e6),
    .entity_7_array (e7),
    .entity_8_flip  (e8),
    .entity_9_flip  (e9),
    .frame_commit   (fc),
    .pkt_err        (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [129:0] sb_q[$];
  logic [129:0] exp_v;
  logic [129:0] dut_vec;
  logic [129:0] reset_vec;
  logic [13:0]  m_sh [9];
  logic [3:0]   m_len;

  assign dut_vec   = {e1, e2, e3, e4, e5, e6, e7, e8, e9};
  assign reset_vec = {{6{14'h3C00}}, 18'h3C000, {2{14'h3C00}}};

  function automatic logic [129:0] model_vec();
    return {m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_sh[4], m_sh[5],
            m_sh[6], m_len, m_sh[7], m_sh[8]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_sh[i] = 14'h3C00;
    m_len = 4'h0;
  endtask

  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int s;
    s = int'(b0[7:4]);
    if (s >= 1 && s <= 9) begin
      m_sh[s-1] = {b0[3:0], b1[7:6], b2};
      if (s == 7) m_len = b1[3:0];
    end
  endtask

  // Scoreboard: every frame_commit must match the oldest pending snapshot.
  always @(negedge clk) begin
    if (rst_n && fc) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL commit_unexpected: got %h, no commit expected", dut_vec);
      end else begin
        exp_v = sb_q.pop_front();
        if (dut_vec !== exp_v)
          $display("FAIL commit_outputs: got %h, expected %h", dut_vec, exp_v);
        else
          passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sif.data_in    = b;
    sif.data_valid = 1'b1;
    step();
    sif.data_valid = 1'b0;
  endtask

  task automatic gap(input int unsigned max_gap);
    if (max_gap != 0) repeat ($urandom_range(max_gap, 1)) step();
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int unsigned max_gap);
    send_byte(b0); gap(max_gap);
    send_byte(b1); gap(max_gap);
    send_byte(b2);
    model_packet(b0, b1, b2);
  endtask

  task automatic do_commit();
    sb_q.push_back(model_vec());
    v_sync = 1'b1;
    step();
    total++;
    if (fc !== 1'b1) $display("FAIL frame_commit_high: got %b, expected 1", fc);
    else passed++;
    step();
    total++;
    if (fc !== 1'b0) $display("FAIL frame_commit_single: got %b, expected 0 with v_sync held", fc);
    else passed++;
    v_sync = 1'b0;
    step();
  endtask

  task automatic test_reset();
    sif.data_in = 8'h00; sif.data_valid = 1'b0; sif.abort = 1'b0;
    model_clear();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    total++;
    if (dut_vec !== reset_vec) $display("FAIL reset_outputs: got %h, expected %h", dut_vec, reset_vec);
    else passed++;
    total++;
    if (err !== 1'b0) $display("FAIL reset_pkt_err: got %b, expected 0", err);
    else passed++;
    total++;
    if (fc !== 1'b0) $display("FAIL reset_frame_commit: got %b, expected 0", fc);
    else passed++;
  endtask

  task automatic test_basic_write();
    send_pkt(8'h25, 8'h80, 8'h47, 0);
    repeat (2) step();
    total++;
    if (e2 !== 14'h3C00) $display("FAIL basic_before_commit: got %h, expected 3c00", e2);
    else passed++;
    do_commit();
    total++;
    if (e2 !== {4'h5, 2'b10, 8'h47}) $display("FAIL basic_entity_2: got %h, expected 1647", e2);
    else passed++;
  endtask

  task automatic test_array();
    send_pkt(8'h73, 8'h46, 8'h10, 0);
    do_commit();
    total++;
    if (e7 !== {4'h3, 2'b01, 8'h10, 4'h6})
      $display("FAIL array_entity_7: got %h, expected %h", e7, {4'h3, 2'b01, 8'h10, 4'h6});
    else passed++;
  endtask

  task automatic test_error_clear();
    send_pkt(8'hA1, 8'h00, 8'h00, 0);
    step();
    total++;
    if (err !== 1'b1) $display("FAIL error_set: got %b, expected 1", err);
    else passed++;
    send_byte(8'hF0);
    model_clear();
    step();
    total++;
    if (err !== 1'b0) $display("FAIL error_cleared: got %b, expected 0", err);
    else passed++;
    do_commit();
    total++;
    if (dut_vec !== reset_vec) $display("FAIL clear_outputs: got %h, expected %h", dut_vec, reset_vec);
    else passed++;
  endtask

  task automatic test_abort_stall();
    send_byte(8'h31);
    sif.abort = 1'b1; sif.data_valid = 1'b1; sif.data_in = 8'h44;
    step();
    sif.abort = 1'b0; sif.data_valid = 1'b0;
    send_pkt(8'h92, 8'h00, 8'h05, 0);
    do_commit();
    total++;
    if (e9 !== 14'h0805) $display("FAIL abort_entity_9: got %h, expected 0805", e9);
    else passed++;
    total++;
    if (e3 !== 14'h3C00) $display("FAIL abort_entity_3: got %h, expected 3c00", e3);
    else passed++;
    send_byte(8'hF0);
    model_clear();
    send_pkt(8'h92, 8'h00, 8'h05, 20);
    do_commit();
    total++;
    if (e9 !== 14'h0805) $display("FAIL stall_entity_9: got %h, expected 0805", e9);
    else passed++;
  endtask

  task automatic test_collision();
    send_byte(8'h4A);
    send_byte(8'h40);
    sb_q.push_back(model_vec());
    sif.data_in = 8'h33; sif.data_valid = 1'b1; v_sync = 1'b1;
    step();
    sif.data_valid = 1'b0;
    model_packet(8'h4A, 8'h40, 8'h33);
    total++;
    if (e4 !== 14'h3C00) $display("FAIL collision_same_commit: got %h, expected 3c00", e4);
    else passed++;
    step();
    v_sync = 1'b0;
    step();
    do_commit();
    total++;
    if (e4 !== {4'hA, 2'b01, 8'h33}) $display("FAIL collision_next_commit: got %h, expected 2933", e4);
    else passed++;
  endtask

  task automatic test_reset_mid_packet();
    send_byte(8'h55);
    send_byte(8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== reset_vec) $display("FAIL async_reset_outputs: got %h, expected %h", dut_vec, reset_vec);
    else passed++;
    model_clear();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_pkt(8'h61, 8'hC0, 8'h22, 0);
    do_commit();
    total++;
    if (e6 !== {4'h1, 2'b11, 8'h22}) $display("FAIL after_reset_entity_6: got %h, expected 0722", e6);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_array();
    test_error_clear();
    test_abort_stall();
    test_collision();
    test_reset_mid_packet();
    repeat (3) step();
    total++;
    if (sb_q.size() != 0) $display("FAIL commits_missing: %0d pending, expected 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
